// File: rtl/seq_serializer.sv
// seq_serializer: parallel-to-serial front end for the sequence detector.
// Accepts WIDTH-bit words over valid/ready and shifts them out one bit per clock.
// A one-word holding buffer lets consecutive words stream with no gap cycles.

module seq_serializer #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MSB_FIRST = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             busy
);

   localparam int unsigned     CntW    = $clog2(WIDTH);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   logic             active_q, active_d;
   logic             hold_full_q, hold_full_d;
   logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic [WIDTH-1:0] shift_next;
   logic             out_bit;
   logic             accept;

   assign load_ready = !hold_full_q && !clear;
   assign accept     = load_valid && load_ready;
   assign busy       = active_q || hold_full_q;
   assign ser_valid  = active_q;

   // Output-end bit selection and one-position shift toward that end, zero-filled.
   always_comb begin
      if (MSB_FIRST != 0) begin
         out_bit    = shift_q[WIDTH-1];
         shift_next = {shift_q[WIDTH-2:0], 1'b0};
      end else begin
         out_bit    = shift_q[0];
         shift_next = {1'b0, shift_q[WIDTH-1:1]};
      end
      ser_out = active_q && out_bit;
   end

   // Next-state: clear, idle load, mid-word shift (maybe hold), last-bit handoff.
   always_comb begin
      active_d    = active_q;
      hold_full_d = hold_full_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      if (clear) begin
         active_d    = 1'b0;
         hold_full_d = 1'b0;
         bit_cnt_d   = '0;
      end else if (!active_q) begin
         if (accept) begin
            shift_d   = load_data;
            bit_cnt_d = '0;
            active_d  = 1'b1;
         end
      end else if (bit_cnt_q != LastCnt) begin
         shift_d   = shift_next;
         bit_cnt_d = bit_cnt_q + CntW'(1);
         if (accept) begin
            hold_d      = load_data;
            hold_full_d = 1'b1;
         end
      end else begin
         // Last bit of the word: a held word has priority over a fresh one.
         if (hold_full_q) begin
            shift_d     = hold_q;
            bit_cnt_d   = '0;
            hold_full_d = 1'b0;
         end else if (accept) begin
            shift_d   = load_data;
            bit_cnt_d = '0;
         end else begin
            active_d = 1'b0;
         end
      end
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         active_q    <= 1'b0;
         hold_full_q <= 1'b0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         hold_q      <= '0;
      end else begin
         active_q    <= active_d;
         hold_full_q <= hold_full_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
      end
   end

endmodule

// File: tb/tb_seq_serializer.sv
// Testbench for seq_serializer: MSB-first and LSB-first instances share stimulus.
// A word-queue reference model predicts every output each cycle.

module tb_seq_serializer;

   localparam int unsigned W = 8;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         clear = 1'b0;
   logic [W-1:0] load_data = '0;
   logic         load_valid = 1'b0;
   logic         ready_m, out_m, valid_m, busy_m;
   logic         ready_l, out_l, valid_l, busy_l;

   int errors = 0;
   int checks = 0;

   seq_serializer #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
      .clock      (clock),
      .reset      (reset),
      .clear      (clear),
      .load_data  (load_data),
      .load_valid (load_valid),
      .load_ready (ready_m),
      .ser_out    (out_m),
      .ser_valid  (valid_m),
      .busy       (busy_m)
   );

   seq_serializer #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
      .clock      (clock),
      .reset      (reset),
      .clear      (clear),
      .load_data  (load_data),
      .load_valid (load_valid),
      .load_ready (ready_l),
      .ser_out    (out_l),
      .ser_valid  (valid_l),
      .busy       (busy_l)
   );

   always #5 clock = ~clock;

   // Reference model: words in flight (front one is shifting) and bit position in it.
   logic [W-1:0] mq[$];
   int           pos = 0;
   logic         acc = 1'b0;

   // Bits actually emitted while ser_valid was high.
   logic str_m[$];
   logic str_l[$];

   typedef struct {
      logic         lv;
      logic [W-1:0] ld;
      logic         eo;
      logic         ev;
      logic         er;
      logic         eb;
   } row_t;

   row_t tbl[10];
   row_t tbl_row;
   logic tbl_en = 1'b0;
   logic [W-1:0] words[3];
   int   idx;

   function automatic row_t mk(logic lv, logic [W-1:0] ld, logic eo, logic ev, logic er,
                               logic eb);
      row_t r;
      r.lv = lv; r.ld = ld; r.eo = eo; r.ev = ev; r.er = er; r.eb = eb;
      return r;
   endfunction

   function automatic logic m_ready();
      return !clear && (mq.size() < 2);
   endfunction

   task automatic model_reset();
      mq.delete();
      pos = 0;
      acc = 1'b0;
   endtask

   task automatic chk(string name, logic act, logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_outputs();
      logic [W-1:0] w;
      logic         v, om, ol;
      v  = mq.size() > 0;
      w  = v ? mq[0] : '0;
      om = v ? w[W-1-pos] : 1'b0;
      ol = v ? w[pos] : 1'b0;
      chk("msb_ser_out",    out_m,   om);
      chk("msb_ser_valid",  valid_m, v);
      chk("msb_busy",       busy_m,  v);
      chk("msb_load_ready", ready_m, m_ready());
      chk("lsb_ser_out",    out_l,   ol);
      chk("lsb_ser_valid",  valid_l, v);
      chk("lsb_busy",       busy_l,  v);
      chk("lsb_load_ready", ready_l, m_ready());
      if (tbl_en) begin
         chk("tbl_ser_out",    out_m,   tbl_row.eo);
         chk("tbl_ser_valid",  valid_m, tbl_row.ev);
         chk("tbl_load_ready", ready_m, tbl_row.er);
         chk("tbl_busy",       busy_m,  tbl_row.eb);
      end
   endtask

   task automatic model_step();
      if (reset) begin
         model_reset();
      end else begin
         acc = load_valid && m_ready();
         if (clear) begin
            mq.delete();
            pos = 0;
         end else begin
            if (mq.size() > 0) begin
               if (pos == W - 1) begin
                  void'(mq.pop_front());
                  pos = 0;
               end else begin
                  pos++;
               end
            end
            if (acc) mq.push_back(load_data);
         end
      end
   endtask

   // One clock: check on the falling edge, advance model on the rising edge.
   task automatic cycle();
      @(negedge clock);
      check_outputs();
      if (valid_m) str_m.push_back(out_m);
      if (valid_l) str_l.push_back(out_l);
      @(posedge clock);
      model_step();
      #1;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   // Compare the emitted bit stream against exp, first bit at exp[n-1].
   task automatic chk_stream(string name, bit lsb, logic [31:0] exp, int n);
      logic        s[$];
      logic [31:0] got;
      logic [31:0] e;
      bit          bad;
      if (lsb) s = str_l; else s = str_m;
      got = '0;
      e   = exp;
      bad = (s.size() != n);
      for (int k = 0; k < s.size() && k < 32; k++) begin
         got = {got[30:0], s[k]};
         if (k < n && s[k] !== e[n-1-k]) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL %s: got %0d bits %h expected %0d bits %h", name, s.size(), got, n, exp);
      end
   endtask

   task automatic clear_streams();
      str_m.delete();
      str_l.delete();
   endtask

   initial begin
      // Single word 0101_1011, MSB first: idle, load, 8 data bits, idle again.
      tbl[0] = mk(1'b1, 8'b0101_1011, 1'b0, 1'b0, 1'b1, 1'b0);
      tbl[1] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
      tbl[2] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
      tbl[3] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
      tbl[4] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
      tbl[5] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
      tbl[6] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
      tbl[7] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
      tbl[8] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
      tbl[9] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

      // Reset state while reset is held.
      #1;
      chk("rst_ser_out",    out_m,   1'b0);
      chk("rst_ser_valid",  valid_m, 1'b0);
      chk("rst_busy",       busy_m,  1'b0);
      chk("rst_load_ready", ready_m, 1'b1);
      idle(2);
      reset = 1'b0;
      idle(2);

      for (int i = 0; i < 10; i++) begin
         load_valid = tbl[i].lv;
         load_data  = tbl[i].ld;
         tbl_row    = tbl[i];
         tbl_en     = 1'b1;
         cycle();
      end
      tbl_en = 1'b0;

      // Back-to-back: A5 then 3C accepted while A5 shifts.
      clear_streams();
      load_valid = 1'b1; load_data = 8'hA5;
      cycle();
      load_data = 8'h3C;
      cycle();
      load_valid = 1'b0;
      idle(20);
      chk_stream("b2b_stream", 1'b0, 32'h0000_A53C, 16);

      // Backpressure: keep load_valid high, advance only on accepted words.
      clear_streams();
      words[0] = 8'hC3; words[1] = 8'h5A; words[2] = 8'h0F;
      idx = 0;
      for (int c = 0; c < 40; c++) begin
         load_valid = (idx < 3);
         load_data  = (idx < 3) ? words[idx] : 8'h00;
         cycle();
         if (acc) idx++;
      end
      load_valid = 1'b0;
      checks++;
      if (idx != 3) begin
         errors++;
         $display("FAIL bp_words_accepted: got %0d expected 3", idx);
      end
      chk_stream("bp_stream", 1'b0, 32'h00C3_5A0F, 24);

      // Asynchronous reset at bit 3 of FF while 00 is held.
      load_valid = 1'b1; load_data = 8'hFF;
      cycle();
      load_data = 8'h00;
      cycle();
      load_valid = 1'b0;
      idle(2);
      #2 reset = 1'b1;
      model_reset();
      #1;
      chk("arst_ser_out",    out_m,   1'b0);
      chk("arst_ser_valid",  valid_m, 1'b0);
      chk("arst_busy",       busy_m,  1'b0);
      chk("arst_load_ready", ready_m, 1'b1);
      chk("arst_lsb_busy",   busy_l,  1'b0);
      cycle();
      reset = 1'b0;
      idle(4);
      clear_streams();
      load_valid = 1'b1; load_data = 8'h81;
      cycle();
      load_valid = 1'b0;
      idle(10);
      chk_stream("post_rst_stream", 1'b0, 32'h0000_0081, 8);

      // Clear at bit 2, then LSB-first reload of 1101_0000.
      load_valid = 1'b1; load_data = 8'b1101_0000;
      cycle();
      load_valid = 1'b0;
      idle(2);
      clear = 1'b1; load_valid = 1'b1;
      #3;
      chk("clear_load_ready", ready_l, 1'b0);
      cycle();
      clear = 1'b0; load_valid = 1'b0;
      chk("clear_ser_valid", valid_l, 1'b0);
      clear_streams();
      cycle();
      load_valid = 1'b1; load_data = 8'b1101_0000;
      cycle();
      load_valid = 1'b0;
      idle(10);
      chk_stream("lsb_stream", 1'b1, 32'h0000_000B, 8);
      chk_stream("msb_stream", 1'b0, 32'h0000_00D0, 8);

      // Randomized traffic with occasional clear and reset.
      for (int c = 0; c < 800; c++) begin
         load_valid = ($urandom_range(0, 99) < 60);
         load_data  = W'($urandom);
         clear      = ($urandom_range(0, 99) < 3);
         reset      = ($urandom_range(0, 199) == 0);
         if (reset) model_reset();
         cycle();
      end
      reset = 1'b0; clear = 1'b0; load_valid = 1'b0;
      idle(12);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_serializer.md
Name: seq_serializer

Overview:
- Parallel-to-serial front end for the sequence detector: accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock.
- ser_out connects directly to the detector's seq_in.
- A one-word holding buffer lets consecutive words stream with no idle bit-cycles between them.
- ser_valid marks cycles carrying real data; idle cycles drive 0.

Parameters:
- WIDTH, 8: bits per word; legal range 2..32.
- MSB_FIRST, 1: 1 = shift bit WIDTH-1 first; 0 = shift bit 0 first.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous flush of shifter and holding buffer.
- load_data  input  WIDTH  word to serialize.
- load_valid  input  1  load_data is valid this cycle.
- load_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  serial bit to sequence detector seq_in.
- ser_valid  output  1  ser_out carries a data bit.
- busy  output  1  shifter active or holding buffer occupied.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. On reset assertion, immediately and independent of clock:
  - active=0, bit_cnt=0, shift_reg=0, hold_full=0, hold_reg=0.
  - Therefore ser_out=0, ser_valid=0, busy=0, load_ready=1.
  - Reset mid-word discards the partial word and any held word; no further bits are emitted.
- State is two flags: active (shifter busy) and hold_full. Derived shifter states:
  - IDLE: active=0.
  - SHIFT: active=1, hold_full=0.
  - SHIFT_HELD: active=1, hold_full=1.
- Combinational outputs:
  - load_ready = !hold_full && !clear.
  - accept = load_valid && load_ready.
  - busy = active || hold_full.
- Registered outputs:
  - ser_valid = active.
  - ser_out = (MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0]) when active, else 0.
- Posedge rules, evaluated in priority order:
  1. clear=1: active=0, hold_full=0, bit_cnt=0. load_ready is 0 this cycle, so no word is accepted.
  2. IDLE and accept: shift_reg=load_data, bit_cnt=0, active=1. The first bit appears on ser_out in the cycle after the accepting edge (latency 1).
  3. Active, bit_cnt < WIDTH-1:
     - Shift one position toward the output end, zero-fill.
     - bit_cnt+1.
     - If accept: hold_reg=load_data, hold_full=1.
  4. Active, bit_cnt == WIDTH-1 (last bit of the word):
     - If hold_full: shift_reg=hold_reg, bit_cnt=0, hold_full=0, active stays 1.
     - Else if accept: shift_reg=load_data, bit_cnt=0, active stays 1.
     - Else: active=0.
- Back-to-back words produce contiguous ser_valid with zero gap cycles.
- Accepting a word on the last-bit cycle while hold is empty loads the shifter directly; it never passes through hold.
- Backpressure: load_ready=0 from the edge that sets hold_full until the edge that moves hold_reg into the shifter.
- Holding a word for the rest of the current word is the only buffering; at most 2 words are in flight.
- Words in: a word is accepted only on an edge where accept=1. load_data is ignored otherwise.
- bit_cnt width is clog2(WIDTH); it never exceeds WIDTH-1.
- With clear and reset both asserted, reset dominates.

Test Plan:
- Reset check: assert reset asynchronously mid-cycle.
  - ser_out=0, ser_valid=0, busy=0 and load_ready=1 immediately, before the next edge.
- Single word, MSB_FIRST=1: load 8'b0101_1011 for one cycle.
  - The next 8 cycles show ser_out 0,1,0,1,1,0,1,1 with ser_valid=1.
  - Then ser_valid=0, ser_out=0, busy=0.
- Back-to-back: load 8'hA5, then 8'h3C while the first word is still shifting.
  - 16 contiguous ser_valid cycles: 1010_0101 then 0011_1100.
  - load_ready=0 from the edge that holds 8'h3C until the last bit of 8'hA5.
- Backpressure: hold load_valid=1 with 3 distinct words, advancing each only when load_ready=1.
  - All 24 bits emitted in order, with no word lost or duplicated.
- Reset mid-operation: reset at bit 3 of 8'hFF while 8'h00 is held.
  - Outputs go idle immediately; no further ser_valid until a new load.
  - A new load of 8'h81 emits 1,0,0,0,0,0,0,1.
- Clear and LSB-first (MSB_FIRST=0):
  - Load 8'b1101_0000, pulse clear at bit 2: ser_valid drops the next cycle, and load_ready=0 during clear even with load_valid=1.
  - Then load 8'b1101_0000: emits 0,0,0,0,1,0,1,1.
  - Feeding this output into the sequence detector asserts det_o on the final 1.
